// File: rtl/skyline_pkg.sv
// Shared constants, types and the LFSR step function for the skyline layer.
package skyline_pkg;

    localparam int             LFSR_W    = 9;
    localparam logic [8:0]     LFSR_SEED = 9'h1FF;
    localparam int             LFSR_TAP  = 4;
    localparam int             BAND_MAX  = 16;

    typedef logic [3:0] height_t;
    typedef logic [4:0] band_t;

    // Fibonacci step: shift left, feed back msb xor tap bit.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_W-1] ^ s[LFSR_TAP]};
    endfunction

endpackage

// File: rtl/skyline_lfsr.sv
// 9-bit column-height LFSR register with reset-to-seed, load and step.
module skyline_lfsr
    import skyline_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_load_val,
    input  logic              i_step,
    output logic [LFSR_W-1:0] o_lfsr
);

    logic [LFSR_W-1:0] r_lfsr;

    // Load has priority over step so a line reload always wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_load) begin
            r_lfsr <= i_load_val;
        end else if (i_step) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/skyline_layer.sv
// One parallax skyline layer: registered building-present flag per pixel.
// Optional window lights are enabled with the SKYLINE_WINDOWS_EN macro.
module skyline_layer
    import skyline_pkg::*;
#(
    parameter int COL_SHIFT  = 3,
    parameter int SCROLL_DIV = 1,
    parameter int HORIZON    = 128,
    parameter int BAND_SHIFT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       visible,
    input  logic       line_start,
    input  logic       frame_start,
    output logic       pixel_on,
`ifdef SKYLINE_WINDOWS_EN
    output logic       window_on,
`endif
    output logic [3:0] col_height
);

    localparam int                DIV_W   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(SCROLL_DIV - 1);

    logic [DIV_W-1:0]     r_frame_div;
    logic [COL_SHIFT-1:0] r_base_sub;
    logic [COL_SHIFT-1:0] r_work_sub;
    band_t                r_band;
    logic                 r_pixel_on;
    height_t              r_col_height;

    logic                 w_advance;
    logic                 w_base_step;
    logic                 w_work_step;
    logic [COL_SHIFT-1:0] w_base_sub_next;
    logic [LFSR_W-1:0]    w_base_lfsr;
    logic [LFSR_W-1:0]    w_base_lfsr_next;
    logic [LFSR_W-1:0]    w_work_lfsr;
    height_t              w_height;
    logic                 w_pixel_on_next;
    logic [9:0]           w_vdiff;
    logic [9:0]           w_band_idx;
    band_t                w_band_next;

    // Post-advance base is what a coincident line_start must load.
    assign w_advance        = frame_start && (r_frame_div == DIV_MAX);
    assign w_base_step      = w_advance && (r_base_sub == '1);
    assign w_base_sub_next  = w_advance ? r_base_sub + 1'b1 : r_base_sub;
    assign w_base_lfsr_next = w_base_step ? lfsr_next(w_base_lfsr) : w_base_lfsr;
    assign w_work_step      = visible && !line_start && (r_work_sub == '1);

    assign w_height         = w_work_lfsr[3:0];
    assign w_pixel_on_next  = visible && ({1'b0, w_height} < r_band);

    always_comb begin
        w_vdiff    = vcount - 10'(HORIZON);
        w_band_idx = w_vdiff >> BAND_SHIFT;
        if (vcount < 10'(HORIZON)) begin
            w_band_next = '0;
        end else if (w_band_idx >= 10'(BAND_MAX - 1)) begin
            w_band_next = band_t'(BAND_MAX);
        end else begin
            w_band_next = band_t'(w_band_idx + 10'd1);
        end
    end

    skyline_lfsr u_base (
        .clk        (clk),
        .rst        (rst),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_step     (w_base_step),
        .o_lfsr     (w_base_lfsr)
    );

    skyline_lfsr u_work (
        .clk        (clk),
        .rst        (rst),
        .i_load     (line_start),
        .i_load_val (w_base_lfsr_next),
        .i_step     (w_work_step),
        .o_lfsr     (w_work_lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_div  <= '0;
            r_base_sub   <= '0;
            r_work_sub   <= '0;
            r_band       <= '0;
            r_pixel_on   <= 1'b0;
            r_col_height <= 4'hF;
        end else begin
            if (frame_start) begin
                r_frame_div <= w_advance ? '0 : r_frame_div + 1'b1;
            end
            r_base_sub <= w_base_sub_next;
            if (line_start) begin
                r_band     <= w_band_next;
                r_work_sub <= w_base_sub_next;
            end else if (visible) begin
                r_work_sub <= r_work_sub + 1'b1;
            end
            r_pixel_on <= w_pixel_on_next;
            if (visible) begin
                r_col_height <= w_height;
            end
        end
    end

    assign pixel_on   = r_pixel_on;
    assign col_height = r_col_height;

    logic w_unused_lfsr;
    assign w_unused_lfsr = ^w_work_lfsr;

`ifdef SKYLINE_WINDOWS_EN
    logic r_window_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_window_on <= 1'b0;
        end else begin
            r_window_on <= w_pixel_on_next && (hcount[1:0] == 2'b01)
                           && (vcount[1:0] == 2'b01) && w_work_lfsr[4];
        end
    end

    assign window_on = r_window_on;
`else
    logic w_unused_hcount;
    assign w_unused_hcount = ^hcount;
`endif

endmodule

// File: tb/tb_skyline_layer.sv
// Directed bench for skyline_layer: bands, scrolling, reload priority, reset, windows.
module tb_skyline_layer;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       visible;
    logic       line_start;
    logic       frame_start;
    logic       pixel_on;
    logic [3:0] col_height;
    logic       pixel_on3;
    logic [3:0] col_height3;
`ifdef SKYLINE_WINDOWS_EN
    logic       window_on;
    logic       window_on3;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    skyline_layer u_dut (
        .clk         (clk),
        .rst         (rst),
        .hcount      (hcount),
        .vcount      (vcount),
        .visible     (visible),
        .line_start  (line_start),
        .frame_start (frame_start),
        .pixel_on    (pixel_on),
`ifdef SKYLINE_WINDOWS_EN
        .window_on   (window_on),
`endif
        .col_height  (col_height)
    );

    skyline_layer #(.SCROLL_DIV(3)) u_dut3 (
        .clk         (clk),
        .rst         (rst),
        .hcount      (hcount),
        .vcount      (vcount),
        .visible     (visible),
        .line_start  (line_start),
        .frame_start (frame_start),
        .pixel_on    (pixel_on3),
`ifdef SKYLINE_WINDOWS_EN
        .window_on   (window_on3),
`endif
        .col_height  (col_height3)
    );

    function automatic logic [8:0] ref_step(input logic [8:0] s);
        return {s[7:0], s[8] ^ s[4]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One blanking cycle carrying line_start (and optionally frame_start).
    task automatic line(input int vc, input logic fs);
        vcount      = 10'(vc);
        visible     = 1'b0;
        line_start  = 1'b1;
        frame_start = fs;
        tick();
        line_start  = 1'b0;
        frame_start = 1'b0;
        chk("blank_dark", 16'(pixel_on), 16'd0);
    endtask

    // n visible pixels from a known work state; expected heights from a reference LFSR.
    task automatic vis_line(input string tag, input int n, input logic [8:0] lf0,
                            input int sub0, input int band);
        logic [8:0] lf;
        int         sub;
        lf  = lf0;
        sub = sub0;
        for (int i = 0; i < n; i++) begin
            visible = 1'b1;
            hcount  = 10'(i);
            tick();
            chk({tag, "_on"}, 16'(pixel_on), 16'(int'(lf[3:0]) < band));
            chk({tag, "_h"}, 16'(col_height), 16'(lf[3:0]));
            if (sub == 7) lf = ref_step(lf);
            sub = (sub + 1) % 8;
        end
        visible = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hcount = '0; vcount = '0;
        visible = 1'b0; line_start = 1'b0; frame_start = 1'b0;
        tick();
        tick();
        chk("rst_pixel_on", 16'(pixel_on), 16'd0);
        chk("rst_col_height", 16'(col_height), 16'hF);
        chk("rst_frame_div3", 16'(u_dut3.r_frame_div), 16'd0);
        rst = 1'b0;

        // Band 15: heights F then E; only E lies below the band.
        line(367, 1'b0);
        vis_line("band15", 16, 9'h1FF, 0, 15);
        tick();
        chk("hblank_dark", 16'(pixel_on), 16'd0);
        chk("hblank_hold", 16'(col_height), 16'hE);

        // Band 16 lights everything; 400 saturates at 16; 127 is above the horizon.
        line(368, 1'b0);
        vis_line("band16", 16, 9'h1FF, 0, 16);
        line(400, 1'b0);
        vis_line("band_sat", 4, 9'h1FF, 0, 16);
        line(127, 1'b0);
        vis_line("band0", 4, 9'h1FF, 0, 0);

        // First frame: scroll one pixel, applied on the coincident line_start.
        line(0, 1'b1);
        chk("div3_f1", 16'(u_dut3.r_frame_div), 16'd1);
        chk("base3_f1", 16'(u_dut3.r_base_sub), 16'd0);
        vis_line("scroll1_same_line", 8, 9'h1FF, 1, 0);
        line(368, 1'b0);
        vis_line("scroll1", 16, 9'h1FF, 1, 16);

        // Frames 2..8: SCROLL_DIV=3 advances on every third frame.
        for (int k = 2; k <= 8; k++) begin
            line(0, 1'b1);
            chk("div3", 16'(u_dut3.r_frame_div), 16'(k % 3));
            chk("base3_sub", 16'(u_dut3.r_base_sub), 16'(k / 3));
            chk("base3_lfsr", 16'(u_dut3.w_base_lfsr), 16'h1FF);
        end
        line(368, 1'b0);
        vis_line("scroll8", 9, 9'h1FE, 0, 16);

        // line_start with visible: pixel from current work (C), then reload to base.
        vcount = 10'd368; hcount = 10'd9; visible = 1'b1; line_start = 1'b1;
        tick();
        line_start = 1'b0;
        chk("collide_on", 16'(pixel_on), 16'd1);
        chk("collide_h", 16'(col_height), 16'hC);
        vis_line("after_collide", 8, 9'h1FE, 0, 16);

        // Mid-line reset returns everything to seed; band 0 keeps it dark.
        line(368, 1'b0);
        vis_line("pre_rst", 3, 9'h1FE, 0, 16);
        rst = 1'b1; visible = 1'b1; hcount = 10'd3;
        tick();
        rst = 1'b0;
        chk("rst_mid_on", 16'(pixel_on), 16'd0);
        chk("rst_mid_h", 16'(col_height), 16'hF);
        chk("rst_mid_div3", 16'(u_dut3.r_frame_div), 16'd0);
        chk("rst_mid_base3", 16'(u_dut3.r_base_sub), 16'd0);
        vis_line("post_rst_dark", 2, 9'h1FF, 0, 0);
        line(368, 1'b0);
        vis_line("post_rst", 1, 9'h1FF, 0, 16);

`ifdef SKYLINE_WINDOWS_EN
        line(369, 1'b0);
        for (int i = 0; i < 3; i++) begin
            visible = 1'b1;
            hcount  = 10'(i);
            tick();
            chk("win_pix", 16'(pixel_on), 16'd1);
            chk("win_on", 16'(window_on), 16'(i == 1));
        end
        visible = 1'b0;
        tick();
        chk("win_blank", 16'(window_on), 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
